// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder: one full adder and one result bit per clock, LSB first.
// Latency: WIDTH+1 edges from the accepting edge to the done pulse.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.

// Single-bit full adder used as the only arithmetic element of the serial datapath.
// Latency: combinational.
// Backpressure: not applicable.
module full_adder_1bit (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// Serial adder top: shifts operands out LSB first through one full adder.
// Latency: done and sum/c_out valid WIDTH+1 edges after start is accepted.
// Backpressure: start ignored in RUN; accepted in IDLE or DONE (back-to-back capable).
module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 bits already produced; the final bit joins them at completion.
    logic [WIDTH-2:0] part_q, part_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] part_nxt;

    full_adder_1bit u_fa (
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_co)
    );

    assign part_nxt = {fa_s, part_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        part_d  = part_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                part_d  = part_nxt[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = part_nxt;
                    c_out_d = fa_co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_serial_adder_8bit.sv
// Scoreboard bench for serial_adder_8bit (WIDTH=8): directed cases, then randomized traffic.
module tb_serial_adder_8bit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
    logic         done;

    serial_adder_8bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [W:0] exp_q[$];
    logic [W:0] exp_val;
    int         cyc = 0;
    int         last_done = -1;
    int         done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Result checker: every done pulse pops one expected {c_out, sum}.
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            chk("busy_with_done", 32'(busy), 32'(0));
            chk("pending_result_at_done", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                exp_val = exp_q.pop_front();
                chk("result", 32'({c_out, sum}), 32'(exp_val));
            end
            if (last_done >= 0)
                chk("done_gap_ge_w1", 32'((cyc - last_done) >= W + 1), 32'(1));
            last_done = cyc;
        end
    end

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a = x;
        b = y;
        c_in = ci;
        start = 1'b1;
        exp_q.push_back((W+1)'(x) + (W+1)'(y) + (W+1)'(ci));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        c_in = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 32'(done), 32'(1));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("reset_sum", 32'(sum), 32'(0));
        chk("reset_c_out", 32'(c_out), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 0x5A + 0x3C: busy for exactly W cycles, then a one-cycle done.
        go(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < W; i++) begin
            chk("t1_busy", 32'(busy), 32'(1));
            chk("t1_no_done_early", 32'(done), 32'(0));
            @(negedge clk);
        end
        chk("t1_done", 32'(done), 32'(1));
        chk("t1_busy_low", 32'(busy), 32'(0));
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'(0));
        chk("t1_idle_busy", 32'(busy), 32'(0));

        // Carry-out cases.
        go(8'hFF, 8'h01, 1'b0);
        wait_done();
        go(8'hFF, 8'h00, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);

        // Start during RUN is ignored.
        d0 = done_cnt;
        go(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        c_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        chk("t3_single_done", 32'(done_cnt - d0), 32'(1));

        // Reset aborts an in-flight operation; first edge after reset accepts start.
        d0 = done_cnt;
        go(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t4_sum_cleared", 32'(sum), 32'(0));
        chk("t4_c_out_cleared", 32'(c_out), 32'(0));
        chk("t4_busy_cleared", 32'(busy), 32'(0));
        chk("t4_done_cleared", 32'(done), 32'(0));
        rst = 1'b0;
        go(8'h01, 8'h01, 1'b0);
        chk("t4_accept_first_edge", 32'(busy), 32'(1));
        wait_done();
        @(negedge clk);
        chk("t4_no_aborted_done", 32'(done_cnt - d0), 32'(1));
        repeat (2) @(negedge clk);

        // Back-to-back start in DONE; previous result held through RUN.
        go(8'h10, 8'h20, 1'b0);
        wait_done();
        go(8'h80, 8'h80, 1'b1);
        chk("t5_busy_next", 32'(busy), 32'(1));
        chk("t5_done_low", 32'(done), 32'(0));
        for (int i = 0; i < W - 1; i++) begin
            chk("t5_sum_held", 32'(sum), 32'(8'h30));
            chk("t5_c_out_held", 32'(c_out), 32'(0));
            @(negedge clk);
        end
        wait_done();

        // Randomized traffic with random spacing and spurious starts during RUN.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            go(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
                c_in = 1'($urandom);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE or DONE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: the operands, captured on the accepting edge.
REQ-006 The block SHALL have port c_in, input, 1 bit: the carry-in, captured on the accepting edge.
REQ-007 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-008 The block SHALL have port c_out, output, 1 bit: the registered carry-out.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking sum/c_out update.

Function
REQ-011 The block SHALL compute each result bit with exactly one instance of full_adder_1bit (x = operand-A LSB, y = operand-B LSB, c_in = carry register); no other adder logic is permitted.
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE; encoding is free.
REQ-013 IDLE/DONE with start=1 on an edge: load a and b into shift registers, load c_in into the carry register, clear the bit counter, go to RUN.
REQ-014 IDLE with start=0: stay in IDLE; DONE with start=0: go to IDLE.
REQ-015 RUN, each edge: shift both operand registers right by 1; shift the full-adder sum bit into the MSB of the partial-result register; load the full-adder c_out into the carry register; increment the counter.
REQ-016 RUN, on the edge that processes bit WIDTH-1: copy the completed partial result to sum, the final carry to c_out, and go to DONE.
REQ-017 Latency: accepting edge E0; bits processed on E1..E_WIDTH; done=1 and sum/c_out valid in the cycle after E_WIDTH (WIDTH+1 edges after start is sampled).
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE (one cycle per completion).
REQ-019 sum and c_out SHALL change only at the completion edge or on reset, and SHALL hold their value through IDLE, RUN and later operations until the next completion.
REQ-020 start during RUN SHALL be ignored, with no effect on the operation in flight; a, b and c_in are don't-care outside the accepting edge.
REQ-021 start in DONE SHALL be accepted (back-to-back), so done and busy are never high together and no idle cycle is inserted.
REQ-022 Arithmetic SHALL be unsigned: {c_out, sum} = a + b + c_in modulo 2^(WIDTH+1).
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-024 rst=1 on an edge SHALL force state IDLE, and busy=0, done=0, sum=0, c_out=0, and clear the carry register, counter and shift registers.
REQ-025 rst SHALL take priority over start and over any in-flight operation; an aborted operation never produces done and never updates sum.
REQ-026 The first edge with rst=0 SHALL accept start if it is asserted.

Verification (WIDTH=8)
REQ-027 a=0x5A, b=0x3C, c_in=0, start one cycle -> busy high 8 cycles, then done one cycle with sum=0x96, c_out=0.
REQ-028 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; then a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
REQ-029 Start 0x12+0x34; pulse start with a=0xFF, b=0xFF on the 3rd RUN cycle -> result is still sum=0x46, c_out=0, and there is exactly one done.
REQ-030 Start 0xAA+0x55, assert rst after 4 RUN cycles -> next cycle all outputs 0, no done pulse; then 0x01+0x01 -> sum=0x02.
REQ-031 Start asserted in the DONE cycle with a=0x80, b=0x80, c_in=1 -> busy rises the next cycle, previous sum held until the second done with sum=0x01, c_out=1.
REQ-032 Randomized bench, ≥1000 operations with random start spacing -> {c_out, sum} matches a+b+c_in, and done spacing is ≥ WIDTH+1 cycles.
